ita_hwpe_seq_ctrl: RTL and testbench

Parametrised job sequencer for the ITA HWPE. It sits between the HWPE slave/register file and the streamer, and issues `req_start` pulses to the input, bias, output and weight sources/sinks. It chains a runtime-selected number of weight loads (1..`N_WPTR`) and detects job completion. It also signals done/clear back to the slave and supports a synchronous abort.

---
 rtl/ita_hwpe_package.sv | 32 +++
 rtl/ita_hwpe_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_ita_hwpe_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ita_hwpe_package.sv
// +----------------------------------------------------------------------------+
// | ita_hwpe_package: shared types and tile-geometry helpers for the ITA HWPE.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ita_hwpe_package;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_LOAD  = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_t;

  // Full weight tile in 8-byte beats.
  function automatic int unsigned seq_full_len(input int unsigned m, input int unsigned n);
    return (m * m) / (n * 8);
  endfunction

  // One row-slice of the weight tile in beats.
  function automatic int unsigned seq_part_len(input int unsigned m);
    return m / 8;
  endfunction

  // Byte offset that skips the slice already preloaded by a previous job.
  function automatic int unsigned seq_skip(input int unsigned m, input int unsigned n);
    return n * m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ita_hwpe_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | ita_hwpe_seq_ctrl: job sequencer issuing streamer starts and weight loads. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ita_hwpe_seq_ctrl
  import ita_hwpe_package::*;
#(
  parameter int unsigned M      = 64,
  parameter int unsigned N      = 16,
  parameter int unsigned N_WPTR = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               start_i,
  input  logic [N_WPTR-1:0][ADDR_W-1:0]      weight_ptr_i,
  input  logic [$clog2(N_WPTR):0]            n_loads_i,
  input  logic                               weight_preload_i,
  input  logic                               bias_disable_i,
  input  logic                               output_disable_i,
  output logic                               input_req_start_o,
  output logic                               bias_req_start_o,
  output logic                               output_req_start_o,
  output logic                               weight_req_start_o,
  output logic [ADDR_W-1:0]                  weight_base_addr_o,
  output logic [LEN_W-1:0]                   weight_len_o,
  input  logic                               weight_done_i,
  input  logic                               input_ready_i,
  input  logic                               weight_ready_i,
  input  logic                               bias_ready_i,
  input  logic                               output_ready_i,
  input  logic                               engine_busy_i,
  input  logic                               fifo_empty_i,
  output logic                               done_o,
  output logic                               clear_o,
  output logic                               busy_o,
  output logic [$clog2(N_WPTR)-1:0]          load_idx_o
);

  localparam int unsigned IDX_W = $clog2(N_WPTR);
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [LEN_W-1:0]  c_full_len = LEN_W'(seq_full_len(M, N));
  localparam logic [LEN_W-1:0]  c_part_len = LEN_W'(seq_part_len(M));
  localparam logic [ADDR_W-1:0] c_skip     = ADDR_W'(seq_skip(M, N));

  seq_state_t         r_state, w_state_d;
  logic [CNT_W-1:0]   r_n_eff, w_n_eff, w_idx_inc;
  logic               r_bias_dis, r_out_dis;
  logic               r_restart;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len;
  logic               w_issue_first, w_issue_next, w_complete;

  assign w_n_eff = (n_loads_i == '0)                ? CNT_W'(1)
                 : (n_loads_i > CNT_W'(N_WPTR))      ? CNT_W'(N_WPTR)
                 :                                     n_loads_i;
  assign w_idx_inc = {1'b0, r_idx} + CNT_W'(1);

  assign w_complete = r_out_dis ? (!engine_busy_i && input_ready_i && weight_ready_i && bias_ready_i)
                                : (output_ready_i && weight_ready_i && fifo_empty_i);

  always_comb begin
    w_state_d          = r_state;
    input_req_start_o  = 1'b0;
    bias_req_start_o   = 1'b0;
    output_req_start_o = 1'b0;
    done_o             = 1'b0;
    clear_o            = 1'b0;
    w_issue_first      = 1'b0;
    w_issue_next       = 1'b0;
    // An abort wins over every other event in the same cycle.
    if (clear_i) begin
      clear_o   = 1'b1;
      w_state_d = SEQ_IDLE;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (start_i) begin
            input_req_start_o  = 1'b1;
            bias_req_start_o   = !bias_disable_i;
            output_req_start_o = !output_disable_i;
            w_issue_first      = 1'b1;
            w_state_d          = (w_n_eff > CNT_W'(1)) ? SEQ_LOAD : SEQ_DRAIN;
          end
        end
        SEQ_LOAD: begin
          if (weight_done_i) begin
            w_issue_next = 1'b1;
            if (w_idx_inc == r_n_eff - CNT_W'(1)) w_state_d = SEQ_DRAIN;
          end
        end
        SEQ_DRAIN: begin
          if (!r_restart && w_complete) begin
            done_o    = 1'b1;
            clear_o   = 1'b1;
            w_state_d = SEQ_IDLE;
          end
        end
        default: w_state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= SEQ_IDLE;
      r_n_eff    <= '0;
      r_bias_dis <= 1'b0;
      r_out_dis  <= 1'b0;
      r_restart  <= 1'b0;
      r_idx      <= '0;
      r_base     <= '0;
      r_len      <= '0;
    end else begin
      r_state   <= w_state_d;
      r_restart <= w_issue_first | w_issue_next;
      if (w_issue_first) begin
        r_n_eff    <= w_n_eff;
        r_bias_dis <= bias_disable_i;
        r_out_dis  <= output_disable_i;
        r_idx      <= '0;
        r_base     <= weight_ptr_i[0] + (weight_preload_i ? '0 : c_skip);
        r_len      <= weight_preload_i ? c_full_len : (c_full_len - c_part_len);
      end else if (w_issue_next) begin
        r_idx  <= r_idx + IDX_W'(1);
        r_base <= weight_ptr_i[r_idx + IDX_W'(1)];
        r_len  <= c_part_len;
      end
    end
  end

  assign weight_req_start_o = r_restart;
  assign weight_base_addr_o = r_base;
  assign weight_len_o       = r_len;
  assign load_idx_o         = r_idx;
  assign busy_o             = (r_state != SEQ_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ita_hwpe_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_ita_hwpe_seq_ctrl: directed self-checking bench for the job sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ita_hwpe_seq_ctrl;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i, start_i;
  logic [3:0][31:0]  weight_ptr_i;
  logic [2:0]        n_loads_i;
  logic              weight_preload_i, bias_disable_i, output_disable_i;
  logic              input_req_start_o, bias_req_start_o, output_req_start_o, weight_req_start_o;
  logic [31:0]       weight_base_addr_o, weight_len_o;
  logic              weight_done_i;
  logic              input_ready_i, weight_ready_i, bias_ready_i, output_ready_i;
  logic              engine_busy_i, fifo_empty_i;
  logic              done_o, clear_o, busy_o;
  logic [1:0]        load_idx_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ita_hwpe_seq_ctrl #(.M(64), .N(16), .N_WPTR(4), .ADDR_W(32), .LEN_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .weight_ptr_i(weight_ptr_i), .n_loads_i(n_loads_i), .weight_preload_i(weight_preload_i),
    .bias_disable_i(bias_disable_i), .output_disable_i(output_disable_i),
    .input_req_start_o(input_req_start_o), .bias_req_start_o(bias_req_start_o),
    .output_req_start_o(output_req_start_o), .weight_req_start_o(weight_req_start_o),
    .weight_base_addr_o(weight_base_addr_o), .weight_len_o(weight_len_o),
    .weight_done_i(weight_done_i), .input_ready_i(input_ready_i), .weight_ready_i(weight_ready_i),
    .bias_ready_i(bias_ready_i), .output_ready_i(output_ready_i), .engine_busy_i(engine_busy_i),
    .fifo_empty_i(fifo_empty_i), .done_o(done_o), .clear_o(clear_o), .busy_o(busy_o),
    .load_idx_o(load_idx_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 0; start_i = 0; weight_done_i = 0;
    weight_ptr_i = '0; n_loads_i = 3'd1; weight_preload_i = 0;
    bias_disable_i = 0; output_disable_i = 0;
    input_ready_i = 1; weight_ready_i = 1; bias_ready_i = 1; output_ready_i = 1;
    engine_busy_i = 0; fifo_empty_i = 1;
    repeat (2) tick();
    #1;
    n_vec++;
    if ({input_req_start_o, bias_req_start_o, output_req_start_o, weight_req_start_o,
         done_o, clear_o, busy_o} !== 7'b0) begin
      n_err++; $display("FAIL reset_pulses got %b want 0000000", {input_req_start_o,
        bias_req_start_o, output_req_start_o, weight_req_start_o, done_o, clear_o, busy_o});
    end
    n_vec++;
    if (weight_base_addr_o !== 32'h0 || weight_len_o !== 32'h0 || load_idx_o !== 2'd0) begin
      n_err++; $display("FAIL reset_regs got base=%h len=%0d idx=%0d want 0/0/0",
        weight_base_addr_o, weight_len_o, load_idx_o);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    weight_ptr_i[0] = 32'h1000; n_loads_i = 3'd1; weight_preload_i = 1; fifo_empty_i = 0;
    start_i = 1; #1;
    n_vec++;
    if ({input_req_start_o, bias_req_start_o, output_req_start_o, weight_req_start_o} !== 4'b1110) begin
      n_err++; $display("FAIL single_start_reqs got %b want 1110", {input_req_start_o,
        bias_req_start_o, output_req_start_o, weight_req_start_o});
    end
    tick(); start_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b1 || weight_base_addr_o !== 32'h1000 ||
        weight_len_o !== 32'd32 || busy_o !== 1'b1) begin
      n_err++; $display("FAIL single_load0 got req=%b base=%h len=%0d busy=%b want 1/1000/32/1",
        weight_req_start_o, weight_base_addr_o, weight_len_o, busy_o);
    end
    tick(); #1;
    n_vec++;
    if (done_o !== 1'b0 || weight_req_start_o !== 1'b0) begin
      n_err++; $display("FAIL single_wait_fifo got done=%b req=%b want 0/0", done_o, weight_req_start_o);
    end
    tick(); fifo_empty_i = 1; #1;
    n_vec++;
    if (done_o !== 1'b1 || clear_o !== 1'b1) begin
      n_err++; $display("FAIL single_done got done=%b clear=%b want 1/1", done_o, clear_o);
    end
    tick(); #1;
    n_vec++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL single_after got done=%b busy=%b want 0/0", done_o, busy_o);
    end
  endtask

  task automatic test_multi_load();
    weight_ptr_i[0] = 32'h1000; weight_ptr_i[1] = 32'h2000; weight_ptr_i[2] = 32'h3000;
    n_loads_i = 3'd3; weight_preload_i = 0;
    start_i = 1; tick(); start_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b1 || weight_base_addr_o !== 32'h1400 ||
        weight_len_o !== 32'd24 || load_idx_o !== 2'd0) begin
      n_err++; $display("FAIL multi_load0 got req=%b base=%h len=%0d idx=%0d want 1/1400/24/0",
        weight_req_start_o, weight_base_addr_o, weight_len_o, load_idx_o);
    end
    tick(); weight_done_i = 1; tick(); weight_done_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b1 || weight_base_addr_o !== 32'h2000 ||
        weight_len_o !== 32'd8 || load_idx_o !== 2'd1) begin
      n_err++; $display("FAIL multi_load1 got req=%b base=%h len=%0d idx=%0d want 1/2000/8/1",
        weight_req_start_o, weight_base_addr_o, weight_len_o, load_idx_o);
    end
    tick(); weight_done_i = 1; tick(); weight_done_i = 0; fifo_empty_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b1 || weight_base_addr_o !== 32'h3000 ||
        weight_len_o !== 32'd8 || load_idx_o !== 2'd2) begin
      n_err++; $display("FAIL multi_load2 got req=%b base=%h len=%0d idx=%0d want 1/3000/8/2",
        weight_req_start_o, weight_base_addr_o, weight_len_o, load_idx_o);
    end
    tick(); weight_done_i = 1; tick(); weight_done_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b0 || load_idx_o !== 2'd2 || weight_base_addr_o !== 32'h3000) begin
      n_err++; $display("FAIL multi_extra_done got req=%b idx=%0d base=%h want 0/2/3000",
        weight_req_start_o, load_idx_o, weight_base_addr_o);
    end
    fifo_empty_i = 1; #1;
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++; $display("FAIL multi_done got %b want 1", done_o);
    end
    tick();
  endtask

  task automatic test_disabled();
    weight_ptr_i[0] = 32'h4000; n_loads_i = 3'd1; weight_preload_i = 1;
    bias_disable_i = 1; output_disable_i = 1;
    engine_busy_i = 1; output_ready_i = 0; fifo_empty_i = 0;
    start_i = 1; #1;
    n_vec++;
    if ({input_req_start_o, bias_req_start_o, output_req_start_o} !== 3'b100) begin
      n_err++; $display("FAIL dis_start_reqs got %b want 100",
        {input_req_start_o, bias_req_start_o, output_req_start_o});
    end
    tick(); start_i = 0; bias_disable_i = 0; output_disable_i = 0;
    tick(); tick(); #1;
    n_vec++;
    if (done_o !== 1'b0) begin
      n_err++; $display("FAIL dis_wait_engine got done=%b want 0", done_o);
    end
    engine_busy_i = 0; #1;
    n_vec++;
    if (done_o !== 1'b1 || clear_o !== 1'b1) begin
      n_err++; $display("FAIL dis_done got done=%b clear=%b want 1/1", done_o, clear_o);
    end
    tick(); output_ready_i = 1; fifo_empty_i = 1;
  endtask

  task automatic test_clear();
    weight_ptr_i[0] = 32'h1000; weight_ptr_i[1] = 32'h2000; n_loads_i = 3'd2; weight_preload_i = 1;
    start_i = 1; tick(); start_i = 0;
    tick(); weight_done_i = 1; clear_i = 1; #1;
    n_vec++;
    if (clear_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++; $display("FAIL clear_cycle got clear=%b done=%b want 1/0", clear_o, done_o);
    end
    tick(); weight_done_i = 0; clear_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL clear_after got req=%b busy=%b done=%b want 0/0/0",
        weight_req_start_o, busy_o, done_o);
    end
    tick(); #1;
    n_vec++;
    if (done_o !== 1'b0 || clear_o !== 1'b0) begin
      n_err++; $display("FAIL clear_idle got done=%b clear=%b want 0/0", done_o, clear_o);
    end
  endtask

  task automatic test_clamp();
    int cnt;
    logic prev;
    bit seen;
    // Zero loads behaves as a single load and completes at the earliest possible cycle.
    weight_ptr_i[0] = 32'h1000; n_loads_i = 3'd0; weight_preload_i = 1;
    start_i = 1; tick(); start_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++; $display("FAIL clamp0_cycle1 got req=%b done=%b want 1/0", weight_req_start_o, done_o);
    end
    tick(); #1;
    n_vec++;
    if (done_o !== 1'b1 || clear_o !== 1'b1) begin
      n_err++; $display("FAIL clamp0_done got done=%b clear=%b want 1/1", done_o, clear_o);
    end
    tick();
    weight_ptr_i = {32'hD000, 32'hC000, 32'hB000, 32'hA000}; n_loads_i = 3'd7;
    start_i = 1; tick(); start_i = 0; fifo_empty_i = 0;
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      weight_done_i = prev; #1;
      if (weight_req_start_o) cnt++;
      prev = weight_req_start_o;
      tick();
    end
    weight_done_i = 0;
    n_vec++;
    if (cnt != 4 || load_idx_o !== 2'd3 || weight_base_addr_o !== 32'hD000) begin
      n_err++; $display("FAIL clamp7_loads got cnt=%0d idx=%0d base=%h want 4/3/d000",
        cnt, load_idx_o, weight_base_addr_o);
    end
    fifo_empty_i = 1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1; if (done_o) seen = 1; else tick();
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL clamp7_done got timeout want done pulse");
    end
    tick();
  endtask

  task automatic test_start_in_drain();
    weight_ptr_i[0] = 32'h5000; n_loads_i = 3'd1; weight_preload_i = 1; fifo_empty_i = 0;
    start_i = 1; tick(); start_i = 0;
    tick(); start_i = 1; #1;
    n_vec++;
    if ({input_req_start_o, bias_req_start_o, output_req_start_o} !== 3'b000) begin
      n_err++; $display("FAIL drain_start_reqs got %b want 000",
        {input_req_start_o, bias_req_start_o, output_req_start_o});
    end
    tick(); start_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b0 || busy_o !== 1'b1 || weight_base_addr_o !== 32'h5000) begin
      n_err++; $display("FAIL drain_start_state got req=%b busy=%b base=%h want 0/1/5000",
        weight_req_start_o, busy_o, weight_base_addr_o);
    end
    fifo_empty_i = 1; #1;
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++; $display("FAIL drain_start_done got %b want 1", done_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // Completion already satisfied while the final restart is outstanding.
    weight_ptr_i[0] = 32'h1000; weight_ptr_i[1] = 32'h2000; n_loads_i = 3'd2; weight_preload_i = 1;
    start_i = 1; tick(); start_i = 0;
    tick(); weight_done_i = 1; tick(); weight_done_i = 0; #1;
    n_vec++;
    if (weight_req_start_o !== 1'b1 || weight_base_addr_o !== 32'h2000 ||
        weight_len_o !== 32'd8 || done_o !== 1'b0) begin
      n_err++; $display("FAIL pend_load1 got req=%b base=%h len=%0d done=%b want 1/2000/8/0",
        weight_req_start_o, weight_base_addr_o, weight_len_o, done_o);
    end
    tick(); #1;
    n_vec++;
    if (done_o !== 1'b1) begin
      n_err++; $display("FAIL pend_done got %b want 1", done_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    weight_ptr_i[0] = 32'h7000; n_loads_i = 3'd3; weight_preload_i = 1;
    start_i = 1; tick(); start_i = 0; #1;
    rst_ni = 1'b0; #1;
    n_vec++;
    if (busy_o !== 1'b0 || weight_req_start_o !== 1'b0 || weight_base_addr_o !== 32'h0 ||
        weight_len_o !== 32'h0) begin
      n_err++; $display("FAIL reset_mid got busy=%b req=%b base=%h len=%0d want 0/0/0/0",
        busy_o, weight_req_start_o, weight_base_addr_o, weight_len_o);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_multi_load();
    test_disabled();
    test_clear();
    test_clamp();
    test_start_in_drain();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
